// File: rtl/smvm_stream_tx_pkg.sv
// Shared constants, state encoding and nonzero entry type for the SMVM stream transmitter.
package smvm_pkg;
  localparam int K          = 4;
  localparam int DATA_W     = 8;
  localparam int IDX_W      = 8;
  localparam int OUT_W      = 12;
  localparam int GAP_CYCLES = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_R,
    ST_HDR_C,
    ST_VEC,
    ST_VAL,
    ST_IDX,
    ST_GAP
  } tx_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic [IDX_W-1:0]  col;
    logic              last;
  } nz_entry_t;
endpackage

// File: rtl/smvm_stream_tx_if.sv
// Serial beat bundle from the transmitter into the SMVM engine inputs.
interface smvm_stream_tx_if;
  import smvm_pkg::*;
  logic [DATA_W-1:0] tx_val;
  logic              tx_ipv;
  logic              tx_valid;

  modport master (output tx_val, output tx_ipv, output tx_valid);
  modport slave  (input  tx_val, input  tx_ipv, input  tx_valid);
endinterface

// File: rtl/smvm_nz_mem.sv
// Nonzero list buffer: {val, col, last} registers, one write port, asynchronous read.
module smvm_nz_mem
  import smvm_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wval,
  input  logic [IDX_W-1:0]  wcol,
  input  logic              wlast,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rval,
  output logic [IDX_W-1:0]  rcol,
  output logic              rlast
);
  nz_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= '{val: wval, col: wcol, last: wlast};
  end

  assign {rval, rcol, rlast} = mem[raddr];
endmodule

// File: rtl/smvm_stream_tx.sv
// SMVM serial frame transmitter: header, vector, K-padded value/index pairs, quiet gap.
// Optional build macro SMVM_TX_ROWCHK_EN adds a row-count check reported on err.
//
// state    | meaning
// ST_IDLE  | waiting for start, buffers writable
// ST_HDR_R | rows header beat
// ST_HDR_C | cols header beat
// ST_VEC   | vector beats, i = 0..cols-1
// ST_VAL   | value beat of pair j (pad 0 past nnz)
// ST_IDX   | column index beat of pair j
// ST_GAP   | tx_valid low; last cycle pulses done and may accept start
module smvm_stream_tx
  import smvm_pkg::*;
#(
  parameter int MAX_SHAPE = 256,
  parameter int MAX_NNZ   = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        cfg_rows,
  input  logic [7:0]        cfg_cols,
  input  logic [8:0]        cfg_nnz,
  input  logic              vec_we,
  input  logic [7:0]        vec_addr,
  input  logic [DATA_W-1:0] vec_wdata,
  input  logic              nz_we,
  input  logic [7:0]        nz_addr,
  input  logic [DATA_W-1:0] nz_val,
  input  logic [IDX_W-1:0]  nz_col,
  input  logic              nz_last,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  smvm_stream_tx_if.master  tx
);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  tx_state_t         state, state_d;
  logic [7:0]        i, i_d;
  logic [8:0]        j, j_d;
  logic [GAP_W-1:0]  gap_cnt, gap_d;
  logic [7:0]        rows_q, cols_q;
  logic [8:0]        nnz_q, pnnz_q, pnnz_calc;
  logic              latch, start_ok, idle_like;
  logic              err_d, done_d, row_err;
  logic [DATA_W-1:0] val_d;
  logic              ipv_d, valid_d;
  logic [DATA_W-1:0] rd_val;
  logic [IDX_W-1:0]  rd_col;
  logic              rd_last;

  logic [DATA_W-1:0] vec_mem [MAX_SHAPE];

  always_ff @(posedge clk) begin
    if (vec_we && !busy) vec_mem[vec_addr] <= vec_wdata;
  end

  smvm_nz_mem #(.DEPTH(MAX_NNZ)) u_nz_mem (
    .clk   (clk),
    .we    (nz_we && !busy),
    .waddr (nz_addr),
    .wval  (nz_val),
    .wcol  (nz_col),
    .wlast (nz_last),
    .raddr (j_d[7:0]),
    .rval  (rd_val),
    .rcol  (rd_col),
    .rlast (rd_last)
  );

  assign pnnz_calc = 9'(((10'(cfg_nnz) + 10'(K - 1)) / 10'(K)) * 10'(K));
  assign start_ok  = (cfg_cols != 8'd0) && (cfg_nnz != 9'd0) && (cfg_nnz <= 9'(MAX_NNZ));
  // The final gap cycle doubles as IDLE for start so frames can run back to back.
  assign idle_like = (state == ST_IDLE) || ((state == ST_GAP) && (gap_cnt == '0));

  always_comb begin
    state_d = state;
    i_d     = i;
    j_d     = j;
    gap_d   = gap_cnt;
    latch   = 1'b0;
    err_d   = 1'b0;
    case (state)
      ST_IDLE:  ;
      ST_HDR_R: state_d = ST_HDR_C;
      ST_HDR_C: begin
        state_d = ST_VEC;
        i_d     = 8'd0;
      end
      ST_VEC: begin
        if (i == cols_q - 8'd1) begin
          state_d = ST_VAL;
          j_d     = 9'd0;
        end else begin
          i_d = i + 8'd1;
        end
      end
      ST_VAL:   state_d = ST_IDX;
      ST_IDX: begin
        j_d = j + 9'd1;
        if (j == pnnz_q - 9'd1) begin
          state_d = ST_GAP;
          gap_d   = GAP_W'(GAP_CYCLES - 1);
        end else begin
          state_d = ST_VAL;
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) state_d = ST_IDLE;
        else               gap_d   = gap_cnt - GAP_W'(1);
      end
      default:  state_d = ST_IDLE;
    endcase

    if (idle_like && start) begin
      if (start_ok) begin
        state_d = ST_HDR_R;
        latch   = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    done_d = (state_d == ST_GAP) && (gap_d == '0);

    // Outputs are registered, so the beat is chosen from the next state.
    val_d   = '0;
    ipv_d   = 1'b0;
    valid_d = 1'b1;
    case (state_d)
      ST_HDR_R: val_d = latch ? cfg_rows : rows_q;
      ST_HDR_C: val_d = cols_q;
      ST_VEC:   val_d = vec_mem[i_d];
      ST_VAL: begin
        if (j_d < nnz_q) begin
          val_d = rd_val;
          ipv_d = rd_last;
        end
      end
      ST_IDX:   if (j_d < nnz_q) val_d = rd_col;
      default:  valid_d = 1'b0;
    endcase
  end

`ifdef SMVM_TX_ROWCHK_EN
  logic [8:0] ipv_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ipv_cnt <= '0;
    else if (latch) ipv_cnt <= '0;
    else if (ipv_d) ipv_cnt <= ipv_cnt + 9'd1;
  end

  assign row_err = (state == ST_IDX) && (state_d == ST_GAP) && (ipv_cnt != {1'b0, rows_q});
`else
  assign row_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      i           <= '0;
      j           <= '0;
      gap_cnt     <= '0;
      rows_q      <= '0;
      cols_q      <= '0;
      nnz_q       <= '0;
      pnnz_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      tx.tx_val   <= '0;
      tx.tx_ipv   <= 1'b0;
      tx.tx_valid <= 1'b0;
    end else begin
      state   <= state_d;
      i       <= i_d;
      j       <= j_d;
      gap_cnt <= gap_d;
      if (latch) begin
        rows_q <= cfg_rows;
        cols_q <= cfg_cols;
        nnz_q  <= cfg_nnz;
        pnnz_q <= pnnz_calc;
      end
      busy        <= (state_d != ST_IDLE);
      done        <= done_d;
      err         <= err_d | row_err;
      tx.tx_val   <= val_d;
      tx.tx_ipv   <= ipv_d;
      tx.tx_valid <= valid_d;
    end
  end
endmodule

// File: tb/tb_smvm_stream_tx.sv
// Directed bench for smvm_stream_tx: frame content, padding, rejects, busy interlock, reset.
module tb_smvm_stream_tx;
  logic       clk;
  logic       rst_n;
  logic [7:0] cfg_rows, cfg_cols;
  logic [8:0] cfg_nnz;
  logic       vec_we;
  logic [7:0] vec_addr, vec_wdata;
  logic       nz_we;
  logic [7:0] nz_addr, nz_val, nz_col;
  logic       nz_last;
  logic       start;
  logic       busy, done, err;

  smvm_stream_tx_if tx ();

  smvm_stream_tx dut (
    .clk(clk), .rst_n(rst_n), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_nnz(cfg_nnz),
    .vec_we(vec_we), .vec_addr(vec_addr), .vec_wdata(vec_wdata),
    .nz_we(nz_we), .nz_addr(nz_addr), .nz_val(nz_val), .nz_col(nz_col), .nz_last(nz_last),
    .start(start), .busy(busy), .done(done), .err(err), .tx(tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Hand-derived stream for rows=2, cols=3, vec {5,6,7}, pairs (1,0)(2,2*)(3,1)(4,2*)(9,1*), pad.
  logic [7:0] exp_v [21] = '{2,3,5,6,7, 1,0, 2,2, 3,1, 4,2, 9,1, 0,0, 0,0, 0,0};
  bit         exp_p [21] = '{0,0,0,0,0, 0,0, 1,0, 0,0, 1,0, 1,0, 0,0, 0,0, 0,0};
  logic [7:0] nzv [5] = '{1,2,3,4,9};
  logic [7:0] nzc [5] = '{0,2,1,2,1};
  bit         nzl [5] = '{0,1,0,1,1};

  logic [7:0] cap_val [600];
  bit         cap_ipv [600];
  int         cap_n, cap_gap, cap_errs, cap_busy_lo;
  bit         cap_done;

  task automatic load_frame(input int n_nz);
    for (int k = 0; k < 5; k++) begin
      vec_we    = (k < 3);
      vec_addr  = 8'(k);
      vec_wdata = 8'(5 + k);
      nz_we     = (k < n_nz);
      nz_addr   = 8'(k);
      nz_val    = nzv[k];
      nz_col    = nzc[k];
      nz_last   = nzl[k];
      @(negedge clk);
    end
    vec_we = 1'b0;
    nz_we  = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] r, input logic [7:0] c, input logic [8:0] n);
    cfg_rows = r;
    cfg_cols = c;
    cfg_nnz  = n;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Records beats while tx_valid is high, then counts low cycles up to and including done.
  task automatic capture(input bit b2b);
    cap_n = 0; cap_gap = 0; cap_errs = 0; cap_busy_lo = 0; cap_done = 0;
    for (int k = 0; k < 32; k++) begin
      cap_val[k] = 8'hxx;
      cap_ipv[k] = 1'b0;
    end
    for (int k = 0; k < 600; k++) begin
      if (tx.tx_valid !== 1'b1) break;
      cap_val[cap_n] = tx.tx_val;
      cap_ipv[cap_n] = tx.tx_ipv;
      if (busy !== 1'b1) cap_busy_lo++;
      if (err === 1'b1)  cap_errs++;
      cap_n++;
      @(negedge clk);
    end
    while (cap_gap < 20) begin
      if (tx.tx_valid === 1'b1) break;
      if (err === 1'b1)  cap_errs++;
      if (busy !== 1'b1) cap_busy_lo++;
      if (tx.tx_val !== 8'd0 || tx.tx_ipv !== 1'b0) cap_errs += 100;
      cap_gap++;
      if (done === 1'b1) begin
        cap_done = 1'b1;
        if (b2b) start = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 0; vec_we = 0; nz_we = 0;
    cfg_rows = 0; cfg_cols = 0; cfg_nnz = 0;
    vec_addr = 0; vec_wdata = 0; nz_addr = 0; nz_val = 0; nz_col = 0; nz_last = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, err, tx.tx_valid, tx.tx_ipv, tx.tx_val} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b valid=%b ipv=%b val=%0d, expected all 0",
               busy, done, err, tx.tx_valid, tx.tx_ipv, tx.tx_val);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    load_frame(4);
    pulse_start(8'd2, 8'd3, 9'd4);
    capture(0);
    vectors++;
    if (cap_n !== 13) begin miscompares++; $display("FAIL basic_len: got %0d beats, expected 13", cap_n); end
    for (int k = 0; k < 13; k++) begin
      vectors++;
      if (cap_val[k] !== exp_v[k] || cap_ipv[k] !== exp_p[k]) begin
        miscompares++;
        $display("FAIL basic_beat%0d: got val=%0d ipv=%0b, expected val=%0d ipv=%0b",
                 k, cap_val[k], cap_ipv[k], exp_v[k], exp_p[k]);
      end
    end
    vectors++;
    if (cap_done !== 1'b1 || cap_gap !== 6) begin
      miscompares++;
      $display("FAIL basic_gap: got done=%0b low_cycles=%0d, expected done=1 low_cycles=6", cap_done, cap_gap);
    end
    vectors++;
    if (cap_busy_lo !== 0 || cap_errs !== 0) begin
      miscompares++;
      $display("FAIL basic_busy_err: got busy_low=%0d err_or_gapdata=%0d, expected 0 and 0", cap_busy_lo, cap_errs);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_idle: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_padding;
    load_frame(5);
    pulse_start(8'd2, 8'd3, 9'd5);
    capture(0);
    vectors++;
    if (cap_n !== 21) begin miscompares++; $display("FAIL pad_len: got %0d beats, expected 21", cap_n); end
    for (int k = 0; k < 21; k++) begin
      vectors++;
      if (cap_val[k] !== exp_v[k] || cap_ipv[k] !== exp_p[k]) begin
        miscompares++;
        $display("FAIL pad_beat%0d: got val=%0d ipv=%0b, expected val=%0d ipv=%0b",
                 k, cap_val[k], cap_ipv[k], exp_v[k], exp_p[k]);
      end
    end
    vectors++;
    if (cap_done !== 1'b1 || cap_gap !== 6) begin
      miscompares++;
      $display("FAIL pad_gap: got done=%0b low_cycles=%0d, expected done=1 low_cycles=6", cap_done, cap_gap);
    end
    @(negedge clk);
  endtask

  task automatic test_reject;
    logic [7:0] bad_cols [3] = '{8'd0, 8'd3, 8'd3};
    logic [8:0] bad_nnz  [3] = '{9'd4, 9'd0, 9'd257};
    for (int r = 0; r < 3; r++) begin
      pulse_start(8'd2, bad_cols[r], bad_nnz[r]);
      vectors++;
      if (err !== 1'b1 || busy !== 1'b0 || tx.tx_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reject%0d_pulse: got err=%b busy=%b valid=%b, expected 1 0 0", r, err, busy, tx.tx_valid);
      end
      @(negedge clk);
      vectors++;
      if (err !== 1'b0 || busy !== 1'b0 || tx.tx_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reject%0d_after: got err=%b busy=%b valid=%b, expected 0 0 0", r, err, busy, tx.tx_valid);
      end
    end
  endtask

  task automatic test_busy_start;
    load_frame(4);
    pulse_start(8'd2, 8'd3, 9'd4);
    fork
      capture(0);
      begin
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    vectors++;
    if (cap_n !== 13 || cap_errs !== 0 || cap_gap !== 6) begin
      miscompares++;
      $display("FAIL busy_start_shape: got beats=%0d errs=%0d gap=%0d, expected 13 0 6", cap_n, cap_errs, cap_gap);
    end
    for (int k = 0; k < 13; k++) begin
      vectors++;
      if (cap_val[k] !== exp_v[k] || cap_ipv[k] !== exp_p[k]) begin
        miscompares++;
        $display("FAIL busy_start_beat%0d: got val=%0d ipv=%0b, expected val=%0d ipv=%0b",
                 k, cap_val[k], cap_ipv[k], exp_v[k], exp_p[k]);
      end
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || tx.tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_start_idle: got busy=%b valid=%b, expected 0 0", busy, tx.tx_valid);
    end
  endtask

  task automatic test_write_drop;
    pulse_start(8'd2, 8'd3, 9'd4);
    fork
      capture(0);
      begin
        repeat (3) @(negedge clk);
        nz_we = 1'b1; nz_addr = 8'd0; nz_val = 8'd99; nz_col = 8'd3; nz_last = 1'b1;
        vec_we = 1'b1; vec_addr = 8'd2; vec_wdata = 8'd77;
        @(negedge clk);
        nz_we = 1'b0; vec_we = 1'b0;
      end
    join
    @(negedge clk);
    pulse_start(8'd2, 8'd3, 9'd4);
    capture(0);
    vectors++;
    if (cap_n !== 13) begin miscompares++; $display("FAIL drop_len: got %0d beats, expected 13", cap_n); end
    for (int k = 0; k < 13; k++) begin
      vectors++;
      if (cap_val[k] !== exp_v[k] || cap_ipv[k] !== exp_p[k]) begin
        miscompares++;
        $display("FAIL drop_beat%0d: got val=%0d ipv=%0b, expected val=%0d ipv=%0b",
                 k, cap_val[k], cap_ipv[k], exp_v[k], exp_p[k]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    pulse_start(8'd2, 8'd3, 9'd4);
    capture(1);
    vectors++;
    if (cap_n !== 13 || cap_done !== 1'b1 || cap_gap !== 6) begin
      miscompares++;
      $display("FAIL b2b_first: got beats=%0d done=%0b gap=%0d, expected 13 1 6", cap_n, cap_done, cap_gap);
    end
    @(negedge clk);
    start = 1'b0;
    capture(0);
    vectors++;
    if (cap_n !== 13) begin miscompares++; $display("FAIL b2b_len: got %0d beats, expected 13", cap_n); end
    for (int k = 0; k < 13; k++) begin
      vectors++;
      if (cap_val[k] !== exp_v[k] || cap_ipv[k] !== exp_p[k]) begin
        miscompares++;
        $display("FAIL b2b_beat%0d: got val=%0d ipv=%0b, expected val=%0d ipv=%0b",
                 k, cap_val[k], cap_ipv[k], exp_v[k], exp_p[k]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    pulse_start(8'd2, 8'd3, 9'd4);
    repeat (3) @(negedge clk);
    vectors++;
    if (tx.tx_valid !== 1'b1 || tx.tx_val !== 8'd6) begin
      miscompares++;
      $display("FAIL rstmid_pre: got valid=%b val=%0d, expected 1 6", tx.tx_valid, tx.tx_val);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, err, tx.tx_valid, tx.tx_ipv, tx.tx_val} !== 13'd0) begin
      miscompares++;
      $display("FAIL rstmid_async: got busy=%b valid=%b val=%0d, expected all 0", busy, tx.tx_valid, tx.tx_val);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || tx.tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_idle: got busy=%b valid=%b, expected 0 0", busy, tx.tx_valid);
    end
    load_frame(4);
    pulse_start(8'd2, 8'd3, 9'd4);
    capture(0);
    vectors++;
    if (cap_n !== 13) begin miscompares++; $display("FAIL rstmid_len: got %0d beats, expected 13", cap_n); end
    for (int k = 0; k < 13; k++) begin
      vectors++;
      if (cap_val[k] !== exp_v[k] || cap_ipv[k] !== exp_p[k]) begin
        miscompares++;
        $display("FAIL rstmid_beat%0d: got val=%0d ipv=%0b, expected val=%0d ipv=%0b",
                 k, cap_val[k], cap_ipv[k], exp_v[k], exp_p[k]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_rowchk;
    pulse_start(8'd3, 8'd3, 9'd4);
    capture(0);
`ifdef SMVM_TX_ROWCHK_EN
    vectors++;
    if (cap_n !== 13 || cap_done !== 1'b1 || cap_errs !== 1) begin
      miscompares++;
      $display("FAIL rowchk_bad: got beats=%0d done=%0b err_pulses=%0d, expected 13 1 1", cap_n, cap_done, cap_errs);
    end
`else
    vectors++;
    if (cap_n !== 13 || cap_done !== 1'b1 || cap_errs !== 0) begin
      miscompares++;
      $display("FAIL rowchk_off: got beats=%0d done=%0b err_pulses=%0d, expected 13 1 0", cap_n, cap_done, cap_errs);
    end
`endif
    @(negedge clk);
    pulse_start(8'd2, 8'd3, 9'd4);
    capture(0);
    vectors++;
    if (cap_n !== 13 || cap_errs !== 0) begin
      miscompares++;
      $display("FAIL rowchk_good: got beats=%0d err_pulses=%0d, expected 13 0", cap_n, cap_errs);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_padding();
    test_reject();
    load_frame(4);
    test_busy_start();
    test_write_drop();
    test_back_to_back();
    test_reset_mid();
    test_rowchk();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
